// File: rtl/ft245_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// ft245_fifo_ctrl_if
//   Bundles the FT245 pin-side signals and the byte-stream handshakes of
//   ft245_fifo_ctrl.
//   slave  : the controller side (drives strobes, bus drive, rx stream,
//            tx_ready).
//   master : the environment side (FT245 flags, bus readback, rx_ready,
//            tx stream).
//   Signals:
//     rxf_n, txe_n       FT245 status flags (active low, asynchronous)
//     rd_n, wr_n         FT245 strobes (active low)
//     data_in            bus value from the pad tristate
//     data_out, data_oe  bus drive value and its output enable
//     rx_data/valid/ready  received byte stream
//     tx_data/valid/ready  byte stream to transmit
// ---------------------------------------------------------------------------
interface ft245_fifo_ctrl_if;
   logic       rxf_n;
   logic       txe_n;
   logic       rd_n;
   logic       wr_n;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport slave (
      input  rxf_n, txe_n, data_in, rx_ready, tx_data, tx_valid,
      output rd_n, wr_n, data_out, data_oe, rx_data, rx_valid, tx_ready
   );

   modport master (
      output rxf_n, txe_n, data_in, rx_ready, tx_data, tx_valid,
      input  rd_n, wr_n, data_out, data_oe, rx_data, rx_valid, tx_ready
   );
endinterface

// File: rtl/ft245_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// ft245_fifo_ctrl
//   Bridges the FT245 asynchronous USB FIFO to a valid/ready byte interface.
//   Reads are strobed out of the FT245 whenever it holds data and the single
//   byte holding register is empty; writes are pushed in when it has space.
//   Both paths share one bidirectional bus and are arbitrated in IDLE with
//   alternating priority on contention.
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   ft245_fifo_ctrl_if.slave (FT245 pins, rx stream, tx stream)
//   All outputs are registered except tx_ready, which is a combinational
//   grant indication valid only in IDLE.
// ---------------------------------------------------------------------------
module ft245_fifo_ctrl #(
   parameter int SYNC_STAGES      = 2,
   parameter int RD_PULSE_CLKS    = 4,
   parameter int RD_RECOVERY_CLKS = 3,
   parameter int WR_SETUP_CLKS    = 1,
   parameter int WR_PULSE_CLKS    = 4,
   parameter int WR_RECOVERY_CLKS = 3
) (
   input logic              clk,
   input logic              rst,
   ft245_fifo_ctrl_if.slave bus
);

   localparam int CNT_W = 16;

   // The recovery windows must outlast the synchroniser so that a flag
   // deasserted by the FT245 after a strobe is seen before IDLE re-arbitrates.
   if (SYNC_STAGES < 1) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 1");
   end
   if (RD_PULSE_CLKS < 1 || WR_SETUP_CLKS < 1 || WR_PULSE_CLKS < 1) begin : g_bad_pulse
      $error("pulse and setup lengths must be at least 1");
   end
   if (RD_RECOVERY_CLKS < SYNC_STAGES + 1) begin : g_bad_rd_recovery
      $error("RD_RECOVERY_CLKS must be at least SYNC_STAGES+1");
   end
   if (WR_RECOVERY_CLKS < SYNC_STAGES + 1) begin : g_bad_wr_recovery
      $error("WR_RECOVERY_CLKS must be at least SYNC_STAGES+1");
   end

   typedef enum logic [2:0] {
      IDLE,
      RD_PULSE,
      RD_RECOVER,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD,
      WR_RECOVER
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] rxf_sr;
   logic [SYNC_STAGES-1:0] txe_sr;
   logic                   rxf_sync;
   logic                   txe_sync;
   logic                   last_grant_tx;
   logic                   rx_elig;
   logic                   tx_elig;
   logic                   grant_rx;
   logic                   grant_tx;
   logic                   tx_hs;
   logic                   rx_hs;
   logic                   rd_n_nxt;
   logic                   wr_n_nxt;
   logic                   data_oe_nxt;

   // True on the last cycle of a state that lasts n cycles.
   function automatic logic at_end(input logic [CNT_W-1:0] c, input int n);
      return c == CNT_W'(n - 1);
   endfunction

   // Flag synchronisers; idle value is "not available".
   always_ff @(posedge clk) begin
      if (rst) begin
         rxf_sr <= '1;
         txe_sr <= '1;
      end else begin
         rxf_sr[0] <= bus.rxf_n;
         txe_sr[0] <= bus.txe_n;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            rxf_sr[i] <= rxf_sr[i-1];
            txe_sr[i] <= txe_sr[i-1];
         end
      end
   end

   assign rxf_sync = rxf_sr[SYNC_STAGES-1];
   assign txe_sync = txe_sr[SYNC_STAGES-1];

   // A read is only eligible when the holding register is empty, which is
   // what provides back-pressure towards the FT245.
   assign rx_elig  = !rxf_sync && !bus.rx_valid;
   assign tx_elig  = !txe_sync && bus.tx_valid;
   assign grant_rx = (state == IDLE) && rx_elig && (!tx_elig || last_grant_tx);
   assign grant_tx = (state == IDLE) && tx_elig && (!rx_elig || !last_grant_tx);

   assign bus.tx_ready = grant_tx && !rst;
   assign tx_hs        = bus.tx_valid && bus.tx_ready;
   assign rx_hs        = bus.rx_valid && bus.rx_ready;

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         last_grant_tx <= 1'b1;
         bus.rd_n      <= 1'b1;
         bus.wr_n      <= 1'b1;
         bus.data_oe   <= 1'b0;
         bus.data_out  <= 8'h00;
         bus.rx_data   <= 8'h00;
         bus.rx_valid  <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
         bus.rd_n    <= rd_n_nxt;
         bus.wr_n    <= wr_n_nxt;
         bus.data_oe <= data_oe_nxt;

         if (grant_rx) begin
            last_grant_tx <= 1'b0;
         end else if (tx_hs) begin
            last_grant_tx <= 1'b1;
         end

         if (tx_hs) begin
            bus.data_out <= bus.tx_data;
         end

         // Capture on the edge that ends the read pulse.
         if (state == RD_PULSE && state_nxt == RD_RECOVER) begin
            bus.rx_data  <= bus.data_in;
            bus.rx_valid <= 1'b1;
         end else if (rx_hs) begin
            bus.rx_valid <= 1'b0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_rx) begin
               state_nxt = RD_PULSE;
            end else if (tx_hs) begin
               state_nxt = WR_SETUP;
            end
         end
         RD_PULSE:   if (at_end(cnt, RD_PULSE_CLKS))    state_nxt = RD_RECOVER;
         RD_RECOVER: if (at_end(cnt, RD_RECOVERY_CLKS)) state_nxt = IDLE;
         WR_SETUP:   if (at_end(cnt, WR_SETUP_CLKS))    state_nxt = WR_PULSE;
         WR_PULSE:   if (at_end(cnt, WR_PULSE_CLKS))    state_nxt = WR_HOLD;
         WR_HOLD:    state_nxt = WR_RECOVER;
         WR_RECOVER: if (at_end(cnt, WR_RECOVERY_CLKS)) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Output decode from the next state, so the registered strobes and the
   // bus enable change on the same edge as the state. rd_n low and data_oe
   // high belong to disjoint states, so they can never overlap.
   always_comb begin
      rd_n_nxt    = (state_nxt != RD_PULSE);
      wr_n_nxt    = (state_nxt != WR_PULSE);
      data_oe_nxt = (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                    (state_nxt == WR_HOLD);
   end

endmodule

// File: tb/tb_ft245_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ft245_fifo_ctrl
//   Bench for ft245_fifo_ctrl. A small FT245 model holds a byte queue that
//   drives rxf_n/data_in and pops on each rd_n rising edge; txe_n follows a
//   bench variable. Expected rx/tx bytes are queued when stimulus is applied
//   and compared when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_ft245_fifo_ctrl;

   localparam int SYNC_STAGES      = 2;
   localparam int RD_PULSE_CLKS    = 4;
   localparam int RD_RECOVERY_CLKS = 3;
   localparam int WR_SETUP_CLKS    = 1;
   localparam int WR_PULSE_CLKS    = 4;
   localparam int WR_RECOVERY_CLKS = 3;

   logic clk;
   logic rst;

   ft245_fifo_ctrl_if ifc ();

   ft245_fifo_ctrl #(
      .SYNC_STAGES      (SYNC_STAGES),
      .RD_PULSE_CLKS    (RD_PULSE_CLKS),
      .RD_RECOVERY_CLKS (RD_RECOVERY_CLKS),
      .WR_SETUP_CLKS    (WR_SETUP_CLKS),
      .WR_PULSE_CLKS    (WR_PULSE_CLKS),
      .WR_RECOVERY_CLKS (WR_RECOVERY_CLKS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] dev_q[$];
   logic [7:0] rx_exp_q[$];
   logic [7:0] tx_exp_q[$];
   int         op_log[$];
   logic       dev_txe_full = 1'b1;
   logic       dev_prev_rd_n = 1'b1;
   logic       mon_en = 1'b0;

   logic       prev_rd_n = 1'b1;
   logic       prev_wr_n = 1'b1;
   logic       prev_oe   = 1'b0;
   logic       rst_q     = 1'b1;
   logic [7:0] prev_dout = 8'h00;
   int rd_cnt = 0, wr_cnt = 0, rx_hs_cnt = 0, tx_rdy_cnt = 0;
   int rd_run = 0, wr_run = 0, oe_run = 0;
   int last_rd_len = 0, last_wr_len = 0, last_oe_len = 0;
   int oe_changes = 0, bus_conflicts = 0, strobe_conflicts = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_rx(input logic [7:0] b);
      dev_q.push_back(b);
      rx_exp_q.push_back(b);
   endtask

   task automatic tx_send(input logic [7:0] b, input bit drop);
      bit hs;
      hs = 1'b0;
      ifc.tx_data  = b;
      ifc.tx_valid = 1'b1;
      for (int t = 0; t < 500 && !hs; t++) begin
         @(negedge clk);
         hs = ifc.tx_ready;
      end
      check_val("tx_handshake", 32'(hs), 1);
      @(posedge clk); #1;
      if (drop) ifc.tx_valid = 1'b0;
   endtask

   // FT245 model: one byte consumed per completed rd_n pulse.
   always @(negedge clk) begin
      if (dev_prev_rd_n == 1'b0 && ifc.rd_n == 1'b1 && dev_q.size() > 0)
         void'(dev_q.pop_front());
      dev_prev_rd_n = ifc.rd_n;
      ifc.rxf_n     = (dev_q.size() == 0);
      ifc.data_in   = (dev_q.size() > 0) ? dev_q[0] : 8'h00;
      ifc.txe_n     = dev_txe_full;
   end

   // Monitor and scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (!ifc.rd_n && ifc.data_oe) bus_conflicts++;
         if (!ifc.rd_n && !ifc.wr_n)   strobe_conflicts++;
         if (ifc.tx_ready) tx_rdy_cnt++;
         if (ifc.tx_valid && ifc.tx_ready) tx_exp_q.push_back(ifc.tx_data);
         if (ifc.rx_valid && ifc.rx_ready) begin
            rx_hs_cnt++;
            check_val("rx_q_nonempty", 32'(rx_exp_q.size() > 0), 1);
            if (rx_exp_q.size() > 0) check_val("rx_byte", 32'(ifc.rx_data), 32'(rx_exp_q.pop_front()));
         end
         if (!ifc.rd_n && prev_rd_n) begin rd_cnt++; op_log.push_back(0); end
         if (!ifc.wr_n && prev_wr_n) begin wr_cnt++; op_log.push_back(1); end
         if (!ifc.rd_n) rd_run++;
         else if (!prev_rd_n) begin
            if (!rst_q) last_rd_len = rd_run;
            rd_run = 0;
         end
         if (!ifc.wr_n) wr_run++;
         else if (!prev_wr_n) begin
            if (!rst_q) last_wr_len = wr_run;
            wr_run = 0;
            if (rst_q) begin
               if (tx_exp_q.size() > 0) void'(tx_exp_q.pop_front());
            end else begin
               check_val("tx_q_nonempty", 32'(tx_exp_q.size() > 0), 1);
               check_val("oe_at_wr_rise", 32'(ifc.data_oe), 1);
               if (tx_exp_q.size() > 0) check_val("tx_byte", 32'(ifc.data_out), 32'(tx_exp_q.pop_front()));
            end
         end
         if (ifc.data_oe) oe_run++;
         else if (prev_oe) begin
            if (!rst_q) last_oe_len = oe_run;
            oe_run = 0;
         end
         if (ifc.data_oe && prev_oe && ifc.data_out != prev_dout) oe_changes++;
      end
      prev_rd_n = ifc.rd_n;
      prev_wr_n = ifc.wr_n;
      prev_oe   = ifc.data_oe;
      prev_dout = ifc.data_out;
      rst_q     = rst;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, n, base, base2, base3;
      rst          = 1'b1;
      ifc.rx_ready = 1'b0;
      ifc.tx_valid = 1'b0;
      ifc.tx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_rd_n",     32'(ifc.rd_n), 1);
      check_val("rst_wr_n",     32'(ifc.wr_n), 1);
      check_val("rst_data_oe",  32'(ifc.data_oe), 0);
      check_val("rst_data_out", 32'(ifc.data_out), 0);
      check_val("rst_rx_data",  32'(ifc.rx_data), 0);
      check_val("rst_rx_valid", 32'(ifc.rx_valid), 0);
      check_val("rst_tx_ready", 32'(ifc.tx_ready), 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single read
      ifc.rx_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      push_rx(8'hA5);
      e = 0;
      while (e < 20) begin
         @(posedge clk); #1; e++;
         if (!ifc.rd_n) break;
      end
      check_val("rd_latency", e, SYNC_STAGES + 1);
      n = 1;
      while (n < 20) begin
         @(posedge clk); #1;
         if (ifc.rd_n) break;
         n++;
      end
      check_val("rd_pulse_len", n, RD_PULSE_CLKS);
      check_val("rx_valid_at_rd_rise", 32'(ifc.rx_valid), 1);
      check_val("rx_data_at_rd_rise",  32'(ifc.rx_data), 32'hA5);
      repeat (10) @(posedge clk);
      #1;

      // Back-pressure
      ifc.rx_ready = 1'b0;
      base = rd_cnt;
      push_rx(8'hC3);
      push_rx(8'h3A);
      e = 0;
      while (!ifc.rx_valid && e < 50) begin @(posedge clk); #1; e++; end
      repeat (40) @(posedge clk);
      #1;
      check_val("bp_single_read",    rd_cnt - base, 1);
      check_val("bp_rx_valid_held",  32'(ifc.rx_valid), 1);
      check_val("bp_rx_data_held",   32'(ifc.rx_data), 32'hC3);
      ifc.rx_ready = 1'b1;
      e = 0;
      while (e < 20) begin
         @(posedge clk); #1; e++;
         if (!ifc.rd_n) break;
      end
      check_val("bp_restart_in_time", 32'(e <= RD_RECOVERY_CLKS + 1), 1);
      e = 0;
      while (rx_exp_q.size() > 0 && e < 100) begin @(posedge clk); #1; e++; end
      check_val("bp_drained", rx_exp_q.size(), 0);
      repeat (5) @(posedge clk);
      #1;

      // Single write
      dev_txe_full = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      base  = tx_rdy_cnt;
      base2 = oe_changes;
      base3 = wr_cnt;
      tx_send(8'h3C, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      check_val("wr_tx_ready_pulse", tx_rdy_cnt - base, 1);
      check_val("wr_oe_len",   last_oe_len, WR_SETUP_CLKS + WR_PULSE_CLKS + 1);
      check_val("wr_pulse_len", last_wr_len, WR_PULSE_CLKS);
      check_val("wr_data_stable", oe_changes - base2, 0);
      check_val("wr_count", wr_cnt - base3, 1);
      check_val("wr_q_empty", tx_exp_q.size(), 0);

      // FT245 full: no write may start whatever tx_data does
      dev_txe_full = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      base  = tx_rdy_cnt;
      base3 = wr_cnt;
      ifc.tx_valid = 1'b1;
      for (int i = 0; i < 25; i++) begin
         ifc.tx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      check_val("full_no_tx_ready", tx_rdy_cnt - base, 0);
      check_val("full_no_write", wr_cnt - base3, 0);
      check_val("full_wr_n", 32'(ifc.wr_n), 1);

      // Contention: both flags fall together, RX wins first then alternate
      ifc.tx_data = 8'h22;
      op_log.delete();
      push_rx(8'h11);
      push_rx(8'h11);
      push_rx(8'h11);
      dev_txe_full = 1'b0;
      fork
         begin
            tx_send(8'h22, 1'b0);
            tx_send(8'h22, 1'b0);
            tx_send(8'h22, 1'b1);
         end
         begin
            int w;
            w = 0;
            while (op_log.size() < 6 && w < 2000) begin @(posedge clk); #1; w++; end
         end
      join
      repeat (20) @(posedge clk);
      #1;
      check_val("cont_op_count", op_log.size(), 6);
      for (int i = 0; i < 6; i++)
         check_val($sformatf("cont_op%0d", i), (i < op_log.size()) ? op_log[i] : 9, i % 2);
      check_val("cont_rx_q_empty", rx_exp_q.size(), 0);
      check_val("cont_tx_q_empty", tx_exp_q.size(), 0);

      // Reset during a read pulse
      ifc.rx_ready = 1'b0;
      push_rx(8'h77);
      e = 0;
      while (ifc.rd_n && e < 50) begin @(posedge clk); #1; e++; end
      check_val("rr_read_started", 32'(ifc.rd_n), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("rr_rd_n",     32'(ifc.rd_n), 1);
      check_val("rr_wr_n",     32'(ifc.wr_n), 1);
      check_val("rr_data_oe",  32'(ifc.data_oe), 0);
      check_val("rr_rx_valid", 32'(ifc.rx_valid), 0);
      check_val("rr_rx_data",  32'(ifc.rx_data), 0);
      rst = 1'b0;
      rx_exp_q.delete();
      ifc.rx_ready = 1'b1;
      base = rx_hs_cnt;
      repeat (30) @(posedge clk);
      #1;
      check_val("rr_no_stale_byte", rx_hs_cnt - base, 0);

      // Reset during a write pulse
      tx_send(8'h5A, 1'b1);
      e = 0;
      while (ifc.wr_n && e < 50) begin @(posedge clk); #1; e++; end
      check_val("rw_write_started", 32'(ifc.wr_n), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_val("rw_rd_n",     32'(ifc.rd_n), 1);
      check_val("rw_wr_n",     32'(ifc.wr_n), 1);
      check_val("rw_data_oe",  32'(ifc.data_oe), 0);
      check_val("rw_rx_valid", 32'(ifc.rx_valid), 0);
      check_val("rw_data_out", 32'(ifc.data_out), 0);
      rst   = 1'b0;
      base3 = wr_cnt;
      repeat (30) @(posedge clk);
      #1;
      check_val("rw_no_stale_write", wr_cnt - base3, 0);
      check_val("rw_tx_q_empty", tx_exp_q.size(), 0);

      check_val("bus_conflicts", bus_conflicts, 0);
      check_val("strobe_conflicts", strobe_conflicts, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
